bcd_display_scanner: RTL and testbench

Upstream of the per-digit seven-segment decoder. Converts a 16-bit binary quantity (e.g. dispensed volume) to four BCD digits with a sequential shift-add-3 (double-dabble) engine. Time-multiplexes the digits onto a single decoder: one digit value per refresh slot plus an active-low one-hot digit enable. Leading zeros are optionally blanked by emitting a code the decoder renders as all segments off.

---
 rtl/bcd_display_scanner_if.sv | 31 +++
 rtl/bcd_display_scanner.sv | 132 +++++++++++++
 tb/tb_bcd_display_scanner.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd_display_scanner_if.sv
// Control and display bus of the BCD display scanner.
// The master side requests conversions; the slave side drives the multiplexed digit outputs.
interface bcd_display_scanner_if;
    logic [15:0] value;
    logic        load;
    logic        blank_leading_zeros;
    logic        busy;
    logic        overflow;
    logic [15:0] digit_value;
    logic [3:0]  digit_select;

    modport master (
        output value,
        output load,
        output blank_leading_zeros,
        input  busy,
        input  overflow,
        input  digit_value,
        input  digit_select
    );

    modport slave (
        input  value,
        input  load,
        input  blank_leading_zeros,
        output busy,
        output overflow,
        output digit_value,
        output digit_select
    );
endinterface

// File: rtl/bcd_display_scanner.sv
// Converts a clamped 16-bit binary value to four BCD digits with a sequential double-dabble engine,
// then time-multiplexes the committed digits onto a single decoder with optional leading-zero blanking.
module bcd_display_scanner #(
    parameter int REFRESH_DIVIDER = 50000
) (
    input logic                    clock,
    input logic                    reset_n,
    bcd_display_scanner_if.slave   bus
);

    localparam int CNT_W = (REFRESH_DIVIDER > 2) ? $clog2(REFRESH_DIVIDER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(REFRESH_DIVIDER - 1);
    localparam logic [15:0]      MAX_DISPLAY = 16'd9999;
    localparam logic [3:0]       LAST_ITER   = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               busy_int;
    logic [31:0]        shift_reg;
    logic [31:0]        dabble_next;
    logic [3:0]         iter_count;
    logic               overflow_reg;
    logic [3:0][3:0]    digits;
    logic [CNT_W-1:0]   refresh_count;
    logic [1:0]         digit_index;
    logic [3:0]         blank_mask;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.load) next_state = CONVERT;
            CONVERT: if (iter_count == LAST_ITER) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy_int = (state != IDLE);
    end

    // One double-dabble iteration: add 3 to every BCD nibble that is 5 or more, then shift the whole register.
    always_comb begin
        logic [31:0] adjusted;
        adjusted = shift_reg;
        for (int n = 0; n < 4; n++) begin
            if (adjusted[16 + 4*n +: 4] >= 4'd5) begin
                adjusted[16 + 4*n +: 4] = adjusted[16 + 4*n +: 4] + 4'd3;
            end
        end
        dabble_next = adjusted << 1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg    <= '0;
            iter_count   <= '0;
            overflow_reg <= 1'b0;
            digits       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        iter_count <= '0;
                        if (bus.value > MAX_DISPLAY) begin
                            shift_reg    <= {16'd0, MAX_DISPLAY};
                            overflow_reg <= 1'b1;
                        end else begin
                            shift_reg    <= {16'd0, bus.value};
                            overflow_reg <= 1'b0;
                        end
                    end
                end
                CONVERT: begin
                    shift_reg  <= dabble_next;
                    iter_count <= iter_count + 4'd1;
                end
                COMMIT: begin
                    digits <= shift_reg[31:16];
                end
                default: ;
            endcase
        end
    end

    // The scanner runs forever, regardless of conversions in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            refresh_count <= '0;
            digit_index   <= '0;
        end else if (refresh_count == CNT_LAST) begin
            refresh_count <= '0;
            digit_index   <= digit_index + 2'd1;
        end else begin
            refresh_count <= refresh_count + 1'b1;
        end
    end

    // A digit is blanked only when it and every more significant digit are zero; units always show.
    always_comb begin
        blank_mask[3] = bus.blank_leading_zeros && (digits[3] == 4'd0);
        blank_mask[2] = blank_mask[3] && (digits[2] == 4'd0);
        blank_mask[1] = blank_mask[2] && (digits[1] == 4'd0);
        blank_mask[0] = 1'b0;
    end

    always_comb begin
        bus.busy         = busy_int;
        bus.overflow     = overflow_reg;
        bus.digit_select = ~(4'b0001 << digit_index);
        if (blank_mask[digit_index]) begin
            bus.digit_value = 16'd15;
        end else begin
            bus.digit_value = {12'd0, digits[digit_index]};
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner: directed scenarios plus randomized loads,
// compared against an arithmetic model of the conversion and scan timing.
module tb_bcd_display_scanner;

    localparam int DIV = 4;

    logic clock;
    logic reset_n;
    int   total;
    int   passed;

    bcd_display_scanner_if bus();

    bcd_display_scanner #(
        .REFRESH_DIVIDER(DIV)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int edge_count;
    int busy_count;
    int committed;
    int pending;
    int accepted;
    logic exp_overflow;

    // Reference model: a load is accepted when idle, the clamped value appears 17 edges later,
    // and the scanned digit index follows from the number of edges since reset.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            edge_count   = 0;
            busy_count   = 0;
            committed    = 0;
            pending      = 0;
            exp_overflow = 1'b0;
        end else begin
            edge_count++;
            if (busy_count == 0) begin
                if (bus.load === 1'b1) begin
                    accepted     = int'(bus.value);
                    exp_overflow = (accepted > 9999);
                    pending      = exp_overflow ? 9999 : accepted;
                    busy_count   = 17;
                end
            end else begin
                busy_count--;
                if (busy_count == 0) committed = pending;
            end
        end
    end

    function automatic int pow10(input int e);
        int p;
        p = 1;
        for (int k = 0; k < e; k++) p = p * 10;
        return p;
    endfunction

    task automatic compareVal(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    task automatic checkOutput(input string tag);
        int          idx;
        int          p;
        logic [15:0] ev;
        logic [3:0]  es;
        idx = (edge_count / DIV) % 4;
        p   = pow10(idx);
        if (bus.blank_leading_zeros && idx >= 1 && committed < p) ev = 16'd15;
        else ev = 16'((committed / p) % 10);
        es = ~(4'b0001 << idx);
        compareVal({tag, "_busy"}, {15'd0, bus.busy}, {15'd0, (busy_count != 0)});
        compareVal({tag, "_ovf"}, {15'd0, bus.overflow}, {15'd0, exp_overflow});
        compareVal({tag, "_val"}, bus.digit_value, ev);
        compareVal({tag, "_sel"}, {12'd0, bus.digit_select}, {12'd0, es});
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        #1;
        checkOutput(tag);
    endtask

    task automatic waitIdle();
        for (int n = 0; n < 40 && bus.busy !== 1'b0; n++) tick("wait_idle");
        compareVal("idle_wait", {15'd0, bus.busy}, 16'd0);
    endtask

    task automatic applyStimulus(input logic [15:0] v);
        waitIdle();
        bus.value = v;
        bus.load  = 1'b1;
        tick("load");
        bus.load  = 1'b0;
    endtask

    task automatic scan(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) tick(tag);
    endtask

    initial begin
        int          busy_cycles;
        logic [15:0] v;
        total   = 0;
        passed  = 0;
        reset_n = 1'b0;
        bus.load = 1'b0;
        bus.value = 16'd0;
        bus.blank_leading_zeros = 1'b1;

        #12;
        checkOutput("reset");
        compareVal("reset_sel", {12'd0, bus.digit_select}, 16'b1110);
        reset_n = 1'b1;
        scan("idle_scan", 6);

        $display("[TB] basic conversion of 1234");
        bus.blank_leading_zeros = 1'b0;
        applyStimulus(16'd1234);
        busy_cycles = 0;
        while (bus.busy === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            tick("conv_1234");
        end
        compareVal("busy_len", 16'(busy_cycles), 16'd17);
        scan("scan_1234", 32);

        $display("[TB] asynchronous reset mid-scan");
        #3 reset_n = 1'b0;
        #1;
        checkOutput("async_reset");
        compareVal("async_sel", {12'd0, bus.digit_select}, 16'b1110);
        compareVal("async_val", bus.digit_value, 16'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        scan("post_reset", 8);

        $display("[TB] blanking");
        bus.blank_leading_zeros = 1'b1;
        applyStimulus(16'd7);
        waitIdle();
        scan("blank_7", 16);
        bus.blank_leading_zeros = 1'b0;
        scan("noblank_7", 16);
        bus.blank_leading_zeros = 1'b1;
        applyStimulus(16'd1005);
        waitIdle();
        scan("blank_1005", 16);

        $display("[TB] overflow");
        applyStimulus(16'd50000);
        compareVal("ovf_set", {15'd0, bus.overflow}, 16'd1);
        waitIdle();
        scan("ovf_9999", 16);
        applyStimulus(16'd0);
        compareVal("ovf_clr", {15'd0, bus.overflow}, 16'd0);
        waitIdle();
        scan("zero", 16);

        $display("[TB] busy protection");
        applyStimulus(16'd42);
        bus.value = 16'd9876;
        bus.load  = 1'b1;
        scan("busy_drop", 17);
        bus.load  = 1'b0;
        scan("show_42", 16);

        $display("[TB] abort during conversion");
        applyStimulus(16'd5555);
        scan("abort_conv", 7);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("abort");
        compareVal("abort_busy", {15'd0, bus.busy}, 16'd0);
        compareVal("abort_sel", {12'd0, bus.digit_select}, 16'b1110);
        @(posedge clock);
        @(posedge clock);
        #1 reset_n = 1'b1;
        scan("after_abort", 24);

        $display("[TB] randomized loads");
        for (int r = 0; r < 20; r++) begin
            bus.blank_leading_zeros = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       v = 16'($urandom_range(0, 9));
                1:       v = 16'($urandom_range(10, 9999));
                2:       v = 16'($urandom_range(10000, 65535));
                default: v = 16'($urandom);
            endcase
            applyStimulus(v);
            for (int c = 0; c < 20; c++) begin
                bus.load  = 1'($urandom_range(0, 1));
                bus.value = 16'($urandom);
                tick("rand_busy");
            end
            bus.load = 1'b0;
            waitIdle();
            scan("rand_scan", 16);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
